// File: rtl/fwd_hazard_ctrl_if.sv
// fwd_hazard_ctrl_if: D-stage instruction fields in, stall/forward selects and stall count out
interface fwd_hazard_ctrl_if;
  logic [4:0] rs_D, rt_D, dst_D;
  logic [1:0] tuse_rs_D, tuse_rt_D, src_D, tnew_D;
  logic we_D, stall;
  logic [3:0] cmp1_sel, cmp2_sel, alua_sel, alub_sel, dmwd_sel;
  logic [15:0] stall_cnt;
  modport master(
    output rs_D, rt_D, dst_D, tuse_rs_D, tuse_rt_D, src_D, tnew_D, we_D,
    input stall, cmp1_sel, cmp2_sel, alua_sel, alub_sel, dmwd_sel, stall_cnt
  );
  modport slave(
    input rs_D, rt_D, dst_D, tuse_rs_D, tuse_rt_D, src_D, tnew_D, we_D,
    output stall, cmp1_sel, cmp2_sel, alua_sel, alub_sel, dmwd_sel, stall_cnt
  );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: E/M/W producer scoreboard driving stall and operand-forward selects
module fwd_hazard_ctrl (
  input logic clk,
  input logic reset,
  fwd_hazard_ctrl_if.slave bus
);
  typedef struct packed {
    logic v, we;
    logic [4:0] dst;
    logic [1:0] src, tnew;
    logic [4:0] rs, rt;
  } ent_t;
  ent_t r_e, r_m, r_w, w_d, w_m, w_w;
  logic [15:0] r_cnt;
  logic w_stall, w_unused;
  function automatic logic hit(ent_t x, logic [4:0] r);
    return x.v && x.we && x.dst != 5'd0 && r != 5'd0 && x.dst == r;
  endfunction
  function automatic logic [3:0] sel_m(ent_t x);
    return x.tnew != 2'd0 ? 4'd0 : x.src == 2'd0 ? 4'd1 : x.src == 2'd1 ? 4'd2 : 4'd0;
  endfunction
  function automatic logic [3:0] sel_w(ent_t x);
    return x.src == 2'd0 ? 4'd3 : x.src == 2'd2 ? 4'd4 : x.src == 2'd1 ? 4'd5 : 4'd0;
  endfunction
  function automatic logic [3:0] fwd(ent_t m, ent_t w, logic [4:0] r);
    return hit(m, r) ? sel_m(m) : hit(w, r) ? sel_w(w) : 4'd0;
  endfunction
  // youngest producer decides; E masks M and a not-yet-ready result stalls
  function automatic logic need(ent_t e, ent_t m, logic [4:0] r, logic [1:0] tuse);
    return tuse != 2'd3 && (hit(e, r) ? e.tnew > tuse : hit(m, r) && m.tnew > tuse);
  endfunction
  always_comb begin
    w_d = '{v: 1'b1, we: bus.we_D, dst: bus.dst_D, src: bus.src_D, tnew: bus.tnew_D,
            rs: bus.rs_D, rt: bus.rt_D};
    w_m = r_e;
    w_m.tnew = r_e.tnew == 2'd0 ? 2'd0 : r_e.tnew - 2'd1;
    w_w = r_m;
    w_w.tnew = 2'd0;
  end
  assign w_stall = need(r_e, r_m, bus.rs_D, bus.tuse_rs_D) | need(r_e, r_m, bus.rt_D, bus.tuse_rt_D);
  assign bus.stall = w_stall;
  assign bus.cmp1_sel = hit(r_e, bus.rs_D) ? 4'd0 : fwd(r_m, r_w, bus.rs_D);
  assign bus.cmp2_sel = hit(r_e, bus.rt_D) ? 4'd0 : fwd(r_m, r_w, bus.rt_D);
  assign bus.alua_sel = r_e.v ? fwd(r_m, r_w, r_e.rs) : 4'd0;
  assign bus.alub_sel = r_e.v ? fwd(r_m, r_w, r_e.rt) : 4'd0;
  assign bus.dmwd_sel = r_m.v && hit(r_w, r_m.rt) ? sel_w(r_w) : 4'd0;
  assign bus.stall_cnt = r_cnt;
  assign w_unused = ^{r_w.rs, r_w.rt, r_w.tnew};
  always_ff @(posedge clk) begin
    if (reset) begin
      r_e <= '0;
      r_m <= '0;
      r_w <= '0;
      r_cnt <= '0;
    end else begin
      r_e <= w_stall ? '0 : w_d;
      r_m <= w_m;
      r_w <= w_w;
      r_cnt <= r_cnt + 16'(w_stall && r_cnt != 16'hFFFF);
    end
  end
endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// tb_fwd_hazard_ctrl: directed MIPS hazard scenarios plus random traffic against an age-based pipeline model
module tb_fwd_hazard_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  fwd_hazard_ctrl_if bus();
  fwd_hazard_ctrl dut(.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  typedef struct {
    bit v, we;
    logic [4:0] dst, rs, rt;
    logic [1:0] src, t0, tr, tt;
  } ins_t;

  ins_t p[3];
  int cnt = 0;
  int errors = 0;
  int checks = 0;
  int code[3][3] = '{'{0, 0, 0}, '{1, 2, 0}, '{3, 5, 4}};
  logic o_st;
  logic [3:0] o_c1, o_c2, o_a, o_b, o_dm;
  logic [15:0] o_cnt;
  bit last_st = 0;

  function automatic ins_t mk(int rs, int rt, int tr, int tt, int dst, bit we, int src);
    ins_t d;
    d.v = 1; d.we = we; d.rs = 5'(rs); d.rt = 5'(rt); d.tr = 2'(tr); d.tt = 2'(tt);
    d.dst = 5'(dst); d.src = 2'(src);
    d.t0 = src == 0 ? 2'd1 : src == 1 ? 2'd0 : 2'd2;
    return d;
  endfunction

  // remaining cycles until result exists, from how many stages it has advanced
  function automatic int rem(int s);
    return int'(p[s].t0) > s ? int'(p[s].t0) - s : 0;
  endfunction
  function automatic int youngest(logic [4:0] r, int lo, int hi);
    for (int s = lo; s <= hi; s++)
      if (p[s].v && p[s].we && p[s].dst != 0 && r != 0 && p[s].dst == r) return s;
    return -1;
  endfunction
  function automatic logic [3:0] fsel(logic [4:0] r, int lo);
    int s = youngest(r, lo, 2);
    if (s < 0 || rem(s) != 0) return 4'd0;
    return 4'(code[s][p[s].src]);
  endfunction
  function automatic bit op_stall(logic [4:0] r, logic [1:0] tuse);
    int s;
    if (r == 0 || tuse == 3) return 0;
    s = youngest(r, 0, 1);
    return s >= 0 && rem(s) > int'(tuse);
  endfunction

  task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle(ins_t d, bit r);
    bit es;
    bus.rs_D = d.rs; bus.rt_D = d.rt; bus.tuse_rs_D = d.tr; bus.tuse_rt_D = d.tt;
    bus.dst_D = d.dst; bus.we_D = d.we; bus.src_D = d.src; bus.tnew_D = d.t0;
    reset = r;
    #4;
    es = op_stall(d.rs, d.tr) | op_stall(d.rt, d.tt);
    o_st = bus.stall; o_c1 = bus.cmp1_sel; o_c2 = bus.cmp2_sel;
    o_a = bus.alua_sel; o_b = bus.alub_sel; o_dm = bus.dmwd_sel; o_cnt = bus.stall_cnt;
    if (!r) begin
      chk("stall", 16'(o_st), 16'(es));
      chk("cmp1_sel", 16'(o_c1), 16'(fsel(d.rs, 0)));
      chk("cmp2_sel", 16'(o_c2), 16'(fsel(d.rt, 0)));
      chk("alua_sel", 16'(o_a), p[0].v ? 16'(fsel(p[0].rs, 1)) : 16'd0);
      chk("alub_sel", 16'(o_b), p[0].v ? 16'(fsel(p[0].rt, 1)) : 16'd0);
      chk("dmwd_sel", 16'(o_dm), p[1].v ? 16'(fsel(p[1].rt, 2)) : 16'd0);
      chk("stall_cnt", o_cnt, 16'(cnt));
    end
    @(posedge clk);
    #1;
    if (r) begin
      for (int s = 0; s < 3; s++) p[s] = '{default: 0};
      cnt = 0;
      es = 0;
    end else begin
      if (es && cnt != 65535) cnt++;
      p[2] = p[1];
      p[1] = p[0];
      if (es) p[0] = '{default: 0};
      else p[0] = d;
    end
    last_st = es;
  endtask

  ins_t nop, d;
  initial begin
    nop = mk(0, 0, 3, 3, 0, 0, 0);
    for (int s = 0; s < 3; s++) p[s] = '{default: 0};
    cycle(nop, 1); cycle(nop, 1);
    cycle(nop, 0);
    chk("rst_stall", 16'(o_st), 16'd0);
    chk("rst_sels", 16'({o_c1, o_c2, o_a, o_b}), 16'd0);
    chk("rst_cnt", o_cnt, 16'd0);
    // load-use: lw $8 then beq $8,$0
    cycle(nop, 1);
    cycle(mk(29, 0, 1, 3, 8, 1, 2), 0);
    d = mk(8, 0, 0, 0, 0, 0, 0);
    cycle(d, 0); chk("lu_stall_a", 16'(o_st), 16'd1);
    cycle(d, 0); chk("lu_stall_b", 16'(o_st), 16'd1);
    cycle(d, 0); chk("lu_go", 16'(o_st), 16'd0); chk("lu_cmp1", 16'(o_c1), 16'd4);
    chk("lu_cnt", o_cnt, 16'd2);
    // ALU to branch
    cycle(nop, 1);
    cycle(mk(1, 2, 1, 1, 9, 1, 0), 0);
    d = mk(9, 0, 0, 0, 0, 0, 0);
    cycle(d, 0); chk("ab_stall", 16'(o_st), 16'd1);
    cycle(d, 0); chk("ab_go", 16'(o_st), 16'd0); chk("ab_cmp1", 16'(o_c1), 16'd1);
    // jal then jr $31 at distances 1, 2, 3
    d = mk(31, 0, 0, 3, 0, 0, 0);
    cycle(nop, 1);
    cycle(mk(0, 0, 3, 3, 31, 1, 1), 0);
    cycle(d, 0); chk("jal_nostall", 16'(o_st), 16'd0);
    cycle(nop, 1);
    cycle(mk(0, 0, 3, 3, 31, 1, 1), 0); cycle(nop, 0);
    cycle(d, 0); chk("jal_m", 16'(o_c1), 16'd2); chk("jal_m_st", 16'(o_st), 16'd0);
    cycle(nop, 1);
    cycle(mk(0, 0, 3, 3, 31, 1, 1), 0); cycle(nop, 0); cycle(nop, 0);
    cycle(d, 0); chk("jal_w", 16'(o_c1), 16'd5);
    // writes to $0
    cycle(nop, 1);
    cycle(mk(1, 2, 1, 1, 0, 1, 0), 0);
    cycle(mk(0, 0, 1, 1, 4, 1, 0), 0);
    chk("z_stall", 16'(o_st), 16'd0); chk("z_cmp", 16'({o_c1, o_c2}), 16'd0);
    cycle(nop, 0); chk("z_alu", 16'({o_a, o_b}), 16'd0);
    // lw $5 then sw $5
    cycle(nop, 1);
    cycle(mk(29, 0, 1, 3, 5, 1, 2), 0);
    cycle(mk(29, 5, 1, 2, 0, 0, 0), 0); chk("sw_nostall", 16'(o_st), 16'd0);
    cycle(nop, 0); cycle(nop, 0); chk("sw_dmwd", 16'(o_dm), 16'd4);
    // double producer, younger wins
    cycle(nop, 1);
    cycle(mk(1, 2, 1, 1, 6, 1, 0), 0);
    cycle(mk(1, 0, 1, 3, 6, 1, 0), 0);
    cycle(mk(6, 0, 1, 1, 7, 1, 0), 0); chk("dp_nostall", 16'(o_st), 16'd0);
    cycle(nop, 0); chk("dp_alua", 16'(o_a), 16'd1);
    // reset during a load-use stall
    cycle(nop, 1);
    cycle(mk(29, 0, 1, 3, 8, 1, 2), 0);
    d = mk(8, 0, 0, 0, 0, 0, 0);
    cycle(d, 0); chk("rs_stall", 16'(o_st), 16'd1);
    cycle(d, 1);
    cycle(d, 0); chk("rs_after", 16'(o_st), 16'd0); chk("rs_cnt", o_cnt, 16'd0);
    // random traffic; stalled D is held like a real pipeline
    for (int i = 0; i < 400; i++) begin
      if (!last_st)
        d = mk($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 3),
               $urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 3) != 0,
               $urandom_range(0, 2));
      cycle(d, $urandom_range(0, 59) == 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
